// File: rtl/aes_cbc_ctrl.sv
// aes_cbc_ctrl: CBC sequencer placed between the bus-side data FIFO and an
// AES-128 core. It accepts one 128-bit block at a time, applies CBC chaining
// around the core, and returns each result on a valid/ready output stream.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   mode_dec_i, key_i    mode (0 = encrypt, 1 = decrypt) and key, sampled at accept
//   iv_i, iv_load_i      IV; a load (IDLE only) also clears blk_cnt_o and err_o
//   in_valid_i/in_ready_o/in_data_i     input block stream
//   out_valid_o/out_ready_i/out_data_o  result stream
//   core_start_enc_o/core_start_dec_o   one-cycle start pulses to the core
//   core_key_o, core_text_o             operands to the core
//   core_text_i, core_ready_i, core_done_i  core result / idle / result strobe
//   busy_o       high whenever not IDLE
//   blk_cnt_o    number of results delivered (wraps)
//   err_o        sticky: core_done_i seen outside WAIT_DONE
module aes_cbc_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_dec_i,
  input  logic [127:0]     key_i,
  input  logic [127:0]     iv_i,
  input  logic             iv_load_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [127:0]     in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [127:0]     out_data_o,
  output logic             core_start_enc_o,
  output logic             core_start_dec_o,
  output logic [127:0]     core_key_o,
  output logic [127:0]     core_text_o,
  input  logic [127:0]     core_text_i,
  input  logic             core_ready_i,
  input  logic             core_done_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] blk_cnt_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, OUT} state_t;

  state_t       state;
  logic         mode_q;   // 1 = decrypt for the block in flight
  logic [127:0] chain;
  logic [127:0] blk_q;    // original input block; becomes the chain on decrypt
  logic [127:0] chain_next;

  // An IV load in the same cycle as an accept must chain from the new IV.
  always_comb chain_next = iv_load_i ? iv_i : chain;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      mode_q           <= 1'b0;
      chain            <= '0;
      blk_q            <= '0;
      core_key_o       <= '0;
      core_text_o      <= '0;
      out_data_o       <= '0;
      blk_cnt_o        <= '0;
      in_ready_o       <= 1'b0;
      out_valid_o      <= 1'b0;
      core_start_enc_o <= 1'b0;
      core_start_dec_o <= 1'b0;
      busy_o           <= 1'b0;
      err_o            <= 1'b0;
    end else begin
      core_start_enc_o <= 1'b0;
      core_start_dec_o <= 1'b0;
      case (state)
        IDLE: begin
          if (iv_load_i) begin
            chain     <= iv_i;
            blk_cnt_o <= '0;
            err_o     <= 1'b0;
          end
          if (in_valid_i && in_ready_o) begin
            mode_q      <= mode_dec_i;
            core_key_o  <= key_i;
            blk_q       <= in_data_i;
            core_text_o <= mode_dec_i ? in_data_i : (in_data_i ^ chain_next);
            in_ready_o  <= 1'b0;
            busy_o      <= 1'b1;
            state       <= ISSUE;
          end else begin
            // Also raises in_ready_o on the first cycle out of reset.
            in_ready_o <= 1'b1;
          end
        end
        ISSUE: begin
          if (core_ready_i) begin
            core_start_enc_o <= ~mode_q;
            core_start_dec_o <= mode_q;
            state            <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // core_ready_i may lag the start pulse, so only done is trusted here.
          if (core_done_i) begin
            out_data_o  <= mode_q ? (core_text_i ^ chain) : core_text_i;
            chain       <= mode_q ? blk_q : core_text_i;
            out_valid_o <= 1'b1;
            state       <= OUT;
          end
        end
        OUT: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            blk_cnt_o   <= blk_cnt_o + CNT_W'(1);
            busy_o      <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Placed last so a stray done wins over a same-cycle IV-load clear.
      if (core_done_i && state != WAIT_DONE) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Testbench for aes_cbc_ctrl: a behavioural core model (known-answer entry
// for the FIPS-197 vector, text ^ key otherwise), a CBC reference model and a
// scoreboard queue checked by an independent output monitor.
module tb_aes_cbc_ctrl;
  localparam int CNT_W = 16;
  localparam logic [127:0] KAT_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 0, rst_n = 0;
  logic mode_dec = 0, iv_load = 0, in_valid = 0, out_ready = 0;
  logic [127:0] key = '0, iv = '0, in_data = '0;
  logic in_ready, out_valid, start_enc, start_dec, busy, err;
  logic [127:0] out_data, core_key, core_text_o, core_res;
  logic [CNT_W-1:0] blk_cnt;
  logic core_ready, core_done, core_done_m = 0, inj_done = 0, hold_nrdy = 0;

  always #5 clk = ~clk;

  aes_cbc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode_dec_i(mode_dec), .key_i(key), .iv_i(iv),
    .iv_load_i(iv_load), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .core_start_enc_o(start_enc),
    .core_start_dec_o(start_dec), .core_key_o(core_key),
    .core_text_o(core_text_o), .core_text_i(core_res),
    .core_ready_i(core_ready), .core_done_i(core_done), .busy_o(busy),
    .blk_cnt_o(blk_cnt), .err_o(err));

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in block cipher: exact for the one known-answer vector, XOR otherwise.
  function automatic logic [127:0] cipher(input logic [127:0] t, input logic [127:0] k, input logic dec);
    if (!dec && t == KAT_P && k == KAT_K) return KAT_C;
    if (dec && t == KAT_C && k == KAT_K) return KAT_P;
    return t ^ k;
  endfunction

  // ---------------- core model ----------------
  int lat_cfg = 11;
  int lat_cnt = 0;
  logic cbusy = 0;
  logic [127:0] cres = '0;
  assign core_ready = !cbusy && !hold_nrdy;
  assign core_done  = core_done_m | inj_done;
  always @(posedge clk) begin
    core_done_m <= 1'b0;
    if (!cbusy && (start_enc || start_dec)) begin
      cbusy   <= 1'b1;
      lat_cnt <= lat_cfg;
      cres    <= cipher(core_text_o, core_key, start_dec);
    end else if (cbusy) begin
      if (lat_cnt <= 1) begin
        cbusy       <= 1'b0;
        core_done_m <= 1'b1;
        core_res    <= cres;
      end else lat_cnt <= lat_cnt - 1;
    end
  end

  // ---------------- start pulse counters ----------------
  int n_enc = 0, n_dec = 0;
  always @(negedge clk) begin
    if (start_enc) n_enc++;
    if (start_dec) n_dec++;
    if (start_enc && start_dec) chk("both_starts", 1, 0);
  end

  // ---------------- reference model + scoreboard ----------------
  logic [127:0] m_chain = '0;
  int m_cnt = 0;
  logic [127:0] exp_q[$];

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", out_data, '0);
      else chk("out_data", out_data, exp_q.pop_front());
    end
  end

  task automatic send(input logic dec, input logic [127:0] k, input logic [127:0] d,
                      input logic ld, input logic [127:0] ivv);
    logic [127:0] r;
    int t = 0;
    mode_dec = dec; key = k; in_data = d; iv_load = ld; iv = ivv; in_valid = 1;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 0; iv_load = 0;
      return;
    end
    if (ld) begin m_chain = ivv; m_cnt = 0; end
    if (!dec) begin
      r = cipher(d ^ m_chain, k, 0);
      m_chain = r;
    end else begin
      r = cipher(d, k, 1) ^ m_chain;
      m_chain = d;
    end
    exp_q.push_back(r);
    @(posedge clk); #1;
    in_valid = 0; iv_load = 0;
  endtask

  task automatic drain(input int hold);
    int t = 0;
    logic [127:0] d0;
    int e0, s0;
    logic stable;
    while (!out_valid && t < 300) begin @(posedge clk); #1; t++; end
    if (!out_valid) begin chk("out_timeout", 0, 1); return; end
    d0 = out_data; e0 = n_enc; s0 = n_dec; stable = 1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (out_data !== d0 || in_ready !== 0 || out_valid !== 1) stable = 0;
    end
    if (hold > 0) begin
      chk("bp_stable", stable, 1);
      chk("bp_no_start", n_enc + n_dec, e0 + s0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    m_cnt++;
    chk("blk_cnt", blk_cnt, m_cnt[CNT_W-1:0]);
    chk("idle_after_out", {busy, in_ready, out_valid}, 3'b010);
  endtask

  initial begin
    int e0, d0;
    // Reset: two cycles low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {in_ready, out_valid, start_enc, start_dec, busy, err}, 0);
    chk("rst_data", out_data | core_key | core_text_o, 0);
    chk("rst_cnt", blk_cnt, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("rdy_after_rst", in_ready, 1);
    inj_done = 1; @(posedge clk); #1; inj_done = 0;
    chk("err_set", err, 1);
    iv_load = 1; iv = '0; @(posedge clk); #1; iv_load = 0;
    chk("err_clear", err, 0);
    m_chain = '0; m_cnt = 0;

    // Known-answer single block, encrypt, IV = 0.
    e0 = n_enc; d0 = n_dec;
    send(0, KAT_K, KAT_P, 1, '0);
    drain(0);
    chk("kat_one_enc", n_enc - e0, 1);
    chk("kat_no_dec", n_dec - d0, 0);

    // CBC chaining with a zero key.
    send(0, '0, 128'h10, 1, 128'h01); drain(0);
    send(0, '0, 128'h20, 0, '0);      drain(0);
    send(1, '0, 128'h11, 1, 128'h01); drain(0);
    send(1, '0, 128'h31, 0, '0);      drain(0);

    // Backpressure: hold the result for five cycles.
    send(0, 128'hABCD, 128'h1234, 0, '0);
    drain(5);

    // Core not ready for seven cycles in ISSUE.
    hold_nrdy = 1;
    e0 = n_enc;
    send(0, 128'h5A, 128'h77, 0, '0);
    repeat (7) @(posedge clk);
    #1;
    chk("nrdy_no_start", n_enc, e0);
    hold_nrdy = 0;
    @(posedge clk); #1;
    chk("nrdy_pulse", start_enc, 1);
    @(posedge clk); #1;
    chk("nrdy_one_pulse", n_enc - e0, 1);
    chk("nrdy_pulse_low", start_enc, 0);
    drain(0);

    // IV load in the same cycle as the accept.
    send(0, '0, 128'h0F, 1, 128'hFF);
    chk("ivld_cnt_clr", blk_cnt, 0);
    drain(0);

    // Randomized mixed traffic.
    for (int i = 0; i < 24; i++) begin
      lat_cfg = $urandom_range(1, 14);
      send($urandom_range(0, 1), {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 4) == 0),
           {$urandom, $urandom, $urandom, $urandom});
      drain($urandom_range(0, 3));
    end

    // Stray done while IDLE sets err without disturbing the stream.
    inj_done = 1; @(posedge clk); #1; inj_done = 0;
    chk("err_stray", err, 1);
    chk("err_state", {busy, in_ready}, 2'b01);

    repeat (3) @(posedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
